ysyx_22040759_mem_stage: RTL

- MEM pipeline stage. Sits between EX and the write-back stage, and is the transmitting end of the ms_to_ws valid/allowin handshake.
- Latches the EX bundle, issues a data-memory load or store over a req/gnt/rvalid interface, and formats load data.
- Presents the 232-bit ms_to_ws bundle to write-back. That bundle holds until write-back accepts it.

---
 rtl/ysyx_22040759_mem_stage_pkg.sv | 59 +++++
 rtl/ysyx_22040759_mem_stage_load_fmt.sv | 29 ++
 rtl/ysyx_22040759_mem_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ysyx_22040759_mem_stage_pkg.sv
// Shared definitions for the MEM stage: widths, encodings and bus field offsets.
// Both pipeline buses are flat vectors; the offsets below locate each field.
package ysyx_22040759_mem_stage_pkg;

   localparam int XLEN     = 64;
   localparam int ES_BUS_W = 237;
   localparam int MS_BUS_W = 232;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2,
      SIZE_D = 2'd3
   } mem_size_e;

   typedef enum logic [1:0] {
      WSEL_ALU = 2'd0,
      WSEL_MEM = 2'd1,
      WSEL_PC4 = 2'd2,
      WSEL_CSR = 2'd3
   } wreg_sel_e;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_REQ  = 2'd1,
      MS_WAIT = 2'd2,
      MS_DONE = 2'd3
   } ms_state_e;

   // {inst, reg_wen, rd, wreg_sel} travels unchanged from EX to WB.
   localparam int WB_INFO_W = 40;

   localparam int ES_PC_LSB   = 0;
   localparam int ES_ALU_LSB  = 64;
   localparam int ES_ST_LSB   = 128;
   localparam int ES_SIGN_BIT = 192;
   localparam int ES_SIZE_LSB = 193;
   localparam int ES_WEN_BIT  = 195;
   localparam int ES_REN_BIT  = 196;
   localparam int ES_WB_LSB   = 197;

   localparam int MS_PC_LSB    = 0;
   localparam int MS_ALU_LSB   = 64;
   localparam int MS_RDATA_LSB = 128;
   localparam int MS_WB_LSB    = 192;

   function automatic logic [7:0] size_mask(input logic [1:0] size);
      logic [7:0] mask;
      case (size)
         SIZE_B:  mask = 8'h01;
         SIZE_H:  mask = 8'h03;
         SIZE_W:  mask = 8'h0F;
         SIZE_D:  mask = 8'hFF;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/ysyx_22040759_mem_stage_load_fmt.sv
// Load data formatter: shifts the addressed bytes of the aligned doubleword
// down to bit 0, then sign- or zero-extends according to the access size.
module ysyx_22040759_load_fmt
   import ysyx_22040759_mem_stage_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      off,
   input  logic [1:0]      size,
   input  logic            sign,
   output logic [XLEN-1:0] result
);

   logic [XLEN-1:0] shifted;

   assign shifted = rdata >> {off, 3'b000};

   // extract the access width and extend it
   always_comb begin
      result = shifted;
      case (size)
         SIZE_B:  result = {{56{sign & shifted[7]}},  shifted[7:0]};
         SIZE_H:  result = {{48{sign & shifted[15]}}, shifted[15:0]};
         SIZE_W:  result = {{32{sign & shifted[31]}}, shifted[31:0]};
         SIZE_D:  result = shifted;
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/ysyx_22040759_mem_stage.sv
// MEM pipeline stage: latches the EX bundle, runs one data-memory access over
// req/gnt/rvalid, and holds the formatted result for write-back.
module ysyx_22040759_mem_stage
   import ysyx_22040759_mem_stage_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                es_to_ms_valid,
   input  logic [ES_BUS_W-1:0] es_to_ms_bus,
   output logic                ms_allowin,
   input  logic                ws_allowin,
   output logic                ms_to_ws_valid,
   output logic [MS_BUS_W-1:0] ms_to_ws_bus,
   output logic                data_req,
   output logic                data_wr,
   output logic [XLEN-1:0]     data_addr,
   output logic [XLEN-1:0]     data_wdata,
   output logic [7:0]          data_wstrb,
   input  logic                data_gnt,
   input  logic                data_rvalid,
   input  logic [XLEN-1:0]     data_rdata
);

   ms_state_e           state;
   ms_state_e           state_next;
   logic                ms_valid;
   logic                ms_ready_go;
   logic                accept;
   logic [ES_BUS_W-1:0] bus;
   logic [XLEN-1:0]     rdata_reg;
   logic [XLEN-1:0]     load_data;

   logic                ren;
   logic                wen;
   logic                sign;
   logic [1:0]          size;
   logic [2:0]          off;
   logic [XLEN-1:0]     alu_result;
   logic [XLEN-1:0]     st_data;

   logic                next_wen;
   logic [1:0]          next_size;
   logic [2:0]          next_off;
   logic [15:0]         strb_wide;

   assign ren        = bus[ES_REN_BIT];
   assign wen        = bus[ES_WEN_BIT];
   assign sign       = bus[ES_SIGN_BIT];
   assign size       = bus[ES_SIZE_LSB +: 2];
   assign alu_result = bus[ES_ALU_LSB +: XLEN];
   assign st_data    = bus[ES_ST_LSB +: XLEN];
   assign off        = alu_result[2:0];

   assign ms_ready_go    = (state == MS_DONE);
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign accept         = es_to_ms_valid && ms_allowin;
   assign ms_to_ws_valid = ms_valid && ms_ready_go;

   assign data_addr  = {alu_result[XLEN-1:3], 3'b000};
   assign data_wdata = st_data << {off, 3'b000};

   assign ms_to_ws_bus[MS_WB_LSB +: WB_INFO_W] = bus[ES_WB_LSB +: WB_INFO_W];
   assign ms_to_ws_bus[MS_RDATA_LSB +: XLEN]   = rdata_reg;
   assign ms_to_ws_bus[MS_ALU_LSB +: XLEN]     = alu_result;
   assign ms_to_ws_bus[MS_PC_LSB +: XLEN]      = bus[ES_PC_LSB +: XLEN];

   ysyx_22040759_load_fmt u_load_fmt (
      .rdata  (data_rdata),
      .off    (off),
      .size   (size),
      .sign   (sign),
      .result (load_data)
   );

   // next-state: a new bundle always wins when the stage can accept
   always_comb begin
      state_next = state;
      if (ms_allowin) begin
         if (es_to_ms_valid) begin
            if (es_to_ms_bus[ES_REN_BIT] || es_to_ms_bus[ES_WEN_BIT]) begin
               state_next = MS_REQ;
            end else begin
               state_next = MS_DONE;
            end
         end else begin
            state_next = MS_IDLE;
         end
      end else begin
         case (state)
            MS_REQ: begin
               if (data_gnt) begin
                  state_next = (ren && !wen) ? MS_WAIT : MS_DONE;
               end else begin
                  state_next = MS_REQ;
               end
            end
            MS_WAIT: begin
               if (data_rvalid) begin
                  state_next = MS_DONE;
               end else begin
                  state_next = MS_WAIT;
               end
            end
            default: state_next = state;
         endcase
      end
   end

   // request attributes for the bundle that will sit in REQ next cycle
   always_comb begin
      next_wen  = wen;
      next_size = size;
      next_off  = off;
      if (accept) begin
         next_wen  = es_to_ms_bus[ES_WEN_BIT];
         next_size = es_to_ms_bus[ES_SIZE_LSB +: 2];
         next_off  = es_to_ms_bus[ES_ALU_LSB +: 3];
      end else begin
         next_wen  = wen;
         next_size = size;
         next_off  = off;
      end
      strb_wide = {8'h00, size_mask(next_size)} << next_off;
   end

   // control state, registered memory request outputs and load result
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= MS_IDLE;
         ms_valid   <= 1'b0;
         data_req   <= 1'b0;
         data_wr    <= 1'b0;
         data_wstrb <= 8'h00;
         rdata_reg  <= {XLEN{1'b0}};
      end else begin
         state      <= state_next;
         if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
         end
         data_req   <= (state_next == MS_REQ);
         data_wr    <= (state_next == MS_REQ) && next_wen;
         data_wstrb <= ((state_next == MS_REQ) && next_wen) ? strb_wide[7:0] : 8'h00;
         if (accept) begin
            rdata_reg <= {XLEN{1'b0}};
         end else if ((state == MS_WAIT) && data_rvalid) begin
            rdata_reg <= load_data;
         end
      end
   end

   // bundle register carries no reset; it is only meaningful while ms_valid
   always_ff @(posedge clk) begin
      if (accept) begin
         bus <= es_to_ms_bus;
      end
   end

endmodule
